pmod_jstk_reader: RTL and testbench
===================================

# pmod_jstk_reader

SPI master that polls a PmodJSTK joystick module and presents its axes and buttons as registered 10-bit/3-bit values. Sits directly upstream of the cursor-update stage: its `joy_x`/`joy_y` outputs drive that stage's joystick inputs, with 512 as the no-motion centre. Runs one 5-byte SPI frame per poll interval and pulses `sample_valid` when a fresh sample is latched.

## Interface
- `CLK_DIV`, 64: SCLK half-period in `clk` cycles; must be ≥ 4.
- `SS_SETUP`, 1500: cycles `ss_n` is low before the first SCLK edge (15 µs at 100 MHz).
- `BYTE_GAP`, 1000: idle cycles between bytes, with `ss_n` held low (10 µs).
- `POLL_GAP`, 1000000: idle cycles from frame end to next frame start (10 ms).
- `clk` input, 1 bit: system clock; all logic on its rising edge.
- `clr_n` input, 1 bit: reset, asynchronous, active-low.
- `led` input, 2 bits: PmodJSTK LED drive; sampled when a frame starts.
- `miso` input, 1 bit: serial data from the joystick; asynchronous, 2-flop synchronised internally.
- `ss_n` output, 1 bit: slave select, active-low.
- `sclk` output, 1 bit: SPI clock, mode 0, idles low.
- `mosi` output, 1 bit: serial command data, MSB first.
- `joy_x` output, 10 bits: X axis, 0..1023.
- `joy_y` output, 10 bits: Y axis, 0..1023.
- `btn` output, 3 bits: {btn2, btn1, stick button}, 1 = pressed.
- `sample_valid` output, 1 bit: one-cycle pulse when `joy_x`/`joy_y`/`btn` update.
- `busy` output, 1 bit: high from frame start until `ss_n` returns high.

## Operation
- FSM states: IDLE → SETUP → SHIFT → GAP → SHIFT … → DONE → IDLE.
- IDLE: `ss_n`=1, `sclk`=0. Counts `POLL_GAP` cycles, then goes to SETUP. The first frame after reset starts after `POLL_GAP` cycles.
- SETUP: `ss_n`=0. Latches `led` and loads the TX byte {6'b100000, led[1], led[0]}. Waits `SS_SETUP` cycles, then goes to SHIFT with byte index 0.
- SHIFT: sends 8 bits. Each bit lasts 2·`CLK_DIV` cycles: `sclk` low for the first `CLK_DIV` cycles, high for the second.
  - `mosi` is updated at the start of each bit.
  - Synchronised `miso` is shifted in on the cycle `sclk` rises.
  - After bit 7, bytes 0–3 go to GAP. Byte 4 goes to DONE.
- GAP: `ss_n`=0, `sclk`=0, TX byte = 0x00. Waits `BYTE_GAP` cycles, increments the byte index, then returns to SHIFT.
- RX bytes, in order: X[7:0], {6'bx, X[9:8]}, Y[7:0], {6'bx, Y[9:8]}, {5'bx, btn[2:0]}. Don't-care bits are ignored. Bytes are stored in holding registers; outputs do not change mid-frame.
- DONE, one cycle: latches `joy_x`/`joy_y`/`btn` from the holding registers and pulses `sample_valid`. `ss_n` goes high on the next edge.
- Reset values:
  - `ss_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `sample_valid`=0.
  - `joy_x`=512, `joy_y`=512, `btn`=0.
  - FSM=IDLE, all counters 0.
- Reset asserted mid-frame: every output goes to its reset value immediately, `ss_n` goes high asynchronously, no `sample_valid` is issued, and the partial frame is discarded.
- `led` changes mid-frame take effect at the next frame.

## Timing
- Frame length with `ss_n` low: `SS_SETUP` + 5·16·`CLK_DIV` + 4·`BYTE_GAP` + 1 cycles.
- `sample_valid` is high in the same cycle the new output values first appear. Outputs hold until the next DONE.
- `busy` rises on the IDLE→SETUP edge and falls together with `ss_n` rising.
- `miso` latency is 2 cycles through the synchroniser. The sampling point is `CLK_DIV` cycles after the falling SCLK edge, so `CLK_DIV` ≥ 4 gives margin.

## Configuration
- `JSTK_AVG_EN` defined: each axis output is a 2-tap average, (previous output + new raw) >> 1. The sum is 11 bits and is truncated. The previous output is 512 after reset.
- `JSTK_AVG_EN` undefined: outputs take the raw values directly.
- `btn` is never averaged.

## Test plan
- Reset with `clr_n`=0 → `joy_x`=`joy_y`=512, `btn`=0, `ss_n`=1, `sclk`=0; no `sample_valid` for `POLL_GAP` cycles.
- Slave model returns X=0x3A5, Y=0x012, buttons=3'b101; `led`=2'b10 → MOSI byte 0 = 0x82, bytes 1–4 = 0x00. One `sample_valid` pulse, with `joy_x`=933, `joy_y`=18, `btn`=5.
- Check the frame against `CLK_DIV`=4, `SS_SETUP`=10, `BYTE_GAP`=8: 40 SCLK rises, `ss_n` low for exactly 10+320+32+1 cycles, `sclk` low during every GAP.
- Pull `clr_n` low during byte 2 → `ss_n`=1 in the same cycle, outputs return to 512/512/0, and a full clean frame follows after `POLL_GAP`.
- `JSTK_AVG_EN` defined, two frames with X=1023 → `joy_x`=767 then 895. Undefined → 1023 both times.
- Change `led` mid-frame from 00 to 11 → current frame's byte 0 = 0x80, next frame's byte 0 = 0x83.

Source files
------------

// File: rtl/pmod_jstk_reader.sv
// SPI mode-0 poller for the PmodJSTK: one 5-byte frame per poll interval, registered axes/buttons.
// Define JSTK_AVG_EN to turn each axis output into a 2-tap running average.
module pmod_jstk_reader #(
    parameter int unsigned CLK_DIV  = 64,
    parameter int unsigned SS_SETUP = 1500,
    parameter int unsigned BYTE_GAP = 1000,
    parameter int unsigned POLL_GAP = 1000000
) (
    input  logic       clk,
    input  logic       clr_n,
    input  logic [1:0] led,
    input  logic       miso,
    output logic       ss_n,
    output logic       sclk,
    output logic       mosi,
    output logic [9:0] joy_x,
    output logic [9:0] joy_y,
    output logic [2:0] btn,
    output logic       sample_valid,
    output logic       busy
);

    localparam int unsigned BIT_LEN = 2 * CLK_DIV;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [2:0]  byte_q, byte_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  xl_q, xl_d;
    logic [1:0]  xh_q, xh_d;
    logic [7:0]  yl_q, yl_d;
    logic [1:0]  yh_q, yh_d;
    logic [2:0]  btn_h_q, btn_h_d;
    logic        miso_s1_q, miso_s2_q;
    logic        ss_n_q, ss_n_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        busy_q, busy_d;
    logic        sample_valid_q, sample_valid_d;
    logic [9:0]  joy_x_q, joy_x_d;
    logic [9:0]  joy_y_q, joy_y_d;
    logic [2:0]  btn_q, btn_d;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            miso_s1_q <= miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bit_q          <= '0;
            byte_q         <= '0;
            tx_q           <= '0;
            rx_q           <= '0;
            xl_q           <= '0;
            xh_q           <= '0;
            yl_q           <= '0;
            yh_q           <= '0;
            btn_h_q        <= '0;
            ss_n_q         <= 1'b1;
            sclk_q         <= 1'b0;
            mosi_q         <= 1'b0;
            busy_q         <= 1'b0;
            sample_valid_q <= 1'b0;
            joy_x_q        <= 10'd512;
            joy_y_q        <= 10'd512;
            btn_q          <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            bit_q          <= bit_d;
            byte_q         <= byte_d;
            tx_q           <= tx_d;
            rx_q           <= rx_d;
            xl_q           <= xl_d;
            xh_q           <= xh_d;
            yl_q           <= yl_d;
            yh_q           <= yh_d;
            btn_h_q        <= btn_h_d;
            ss_n_q         <= ss_n_d;
            sclk_q         <= sclk_d;
            mosi_q         <= mosi_d;
            busy_q         <= busy_d;
            sample_valid_q <= sample_valid_d;
            joy_x_q        <= joy_x_d;
            joy_y_q        <= joy_y_d;
            btn_q          <= btn_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bit_d          = bit_q;
        byte_d         = byte_q;
        tx_d           = tx_q;
        rx_d           = rx_q;
        xl_d           = xl_q;
        xh_d           = xh_q;
        yl_d           = yl_q;
        yh_d           = yh_q;
        btn_h_d        = btn_h_q;
        mosi_d         = mosi_q;
        sample_valid_d = 1'b0;
        joy_x_d        = joy_x_q;
        joy_y_d        = joy_y_q;
        btn_d          = btn_q;

        case (state_q)
            IDLE: begin
                mosi_d = 1'b0;
                if (cnt_q == POLL_GAP - 1) begin
                    state_d = SETUP;
                    cnt_d   = '0;
                    tx_d    = {6'b100000, led};
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            SETUP: begin
                if (cnt_q == SS_SETUP - 1) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    byte_d  = '0;
                    mosi_d  = tx_q[7];
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            SHIFT: begin
                // Sample on the cycle sclk rises; miso_s2_q is already 2 cycles behind the pin.
                if (cnt_q == CLK_DIV - 1) begin
                    rx_d = {rx_q[6:0], miso_s2_q};
                end
                if (cnt_q == BIT_LEN - 1) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        case (byte_q)
                            3'd0:    xl_d    = rx_q;
                            3'd1:    xh_d    = rx_q[1:0];
                            3'd2:    yl_d    = rx_q;
                            3'd3:    yh_d    = rx_q[1:0];
                            default: btn_h_d = rx_q[2:0];
                        endcase
                        mosi_d = 1'b0;
                        if (byte_q == 3'd4) begin
                            state_d = DONE;
                        end else begin
                            state_d = GAP;
                            tx_d    = 8'h00;
                        end
                    end else begin
                        bit_d  = bit_q + 3'd1;
                        tx_d   = {tx_q[6:0], 1'b0};
                        mosi_d = tx_q[6];
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            GAP: begin
                mosi_d = 1'b0;
                if (cnt_q == BYTE_GAP - 1) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    byte_d  = byte_q + 3'd1;
                    mosi_d  = tx_q[7];
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            DONE: begin
`ifdef JSTK_AVG_EN
                joy_x_d = 10'(({1'b0, joy_x_q} + {1'b0, xh_q, xl_q}) >> 1);
                joy_y_d = 10'(({1'b0, joy_y_q} + {1'b0, yh_q, yl_q}) >> 1);
`else
                joy_x_d = {xh_q, xl_q};
                joy_y_d = {yh_q, yl_q};
`endif
                btn_d          = btn_h_q;
                sample_valid_d = 1'b1;
                state_d        = IDLE;
                cnt_d          = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pin-level outputs are registered from the next state so they never glitch.
    assign ss_n_d = (state_d == IDLE);
    assign busy_d = (state_d != IDLE);
    assign sclk_d = (state_d == SHIFT) && (cnt_d >= CLK_DIV);

    assign ss_n         = ss_n_q;
    assign sclk         = sclk_q;
    assign mosi         = mosi_q;
    assign busy         = busy_q;
    assign sample_valid = sample_valid_q;
    assign joy_x        = joy_x_q;
    assign joy_y        = joy_y_q;
    assign btn          = btn_q;

endmodule

// File: tb/tb_pmod_jstk_reader.sv
// Bench for pmod_jstk_reader: joystick slave model, frame monitor and sample scoreboard.
module tb_pmod_jstk_reader;

    localparam int unsigned CLK_DIV  = 4;
    localparam int unsigned SS_SETUP = 10;
    localparam int unsigned BYTE_GAP = 8;
    localparam int unsigned POLL_GAP = 50;
    localparam int unsigned FRAME_LOW = SS_SETUP + 5 * 16 * CLK_DIV + 4 * BYTE_GAP + 1;
`ifdef JSTK_AVG_EN
    localparam bit AVG_EN = 1'b1;
`else
    localparam bit AVG_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] rises;
        logic [31:0] low;
        logic [7:0]  b0;
        logic [31:0] rest;
        logic        gap_bad;
    } frame_t;

    logic       clk;
    logic       clr_n = 1'b0;
    logic [1:0] led   = 2'b00;
    logic       miso  = 1'b0;
    logic       ss_n, sclk, mosi, sample_valid, busy;
    logic [9:0] joy_x, joy_y;
    logic [2:0] btn;

    int total = 0;
    int bad   = 0;

    logic [22:0] exp_q[$];
    logic [7:0]  exp_b0_q[$];
    frame_t      frame_q[$];
    logic [9:0]  m_x = 10'd512;
    logic [9:0]  m_y = 10'd512;
    int          frames_done = 0;

    logic [9:0]  sl_x = '0;
    logic [9:0]  sl_y = '0;
    logic [2:0]  sl_b = '0;

    pmod_jstk_reader #(
        .CLK_DIV (CLK_DIV),
        .SS_SETUP(SS_SETUP),
        .BYTE_GAP(BYTE_GAP),
        .POLL_GAP(POLL_GAP)
    ) dut (
        .clk         (clk),
        .clr_n       (clr_n),
        .led         (led),
        .miso        (miso),
        .ss_n        (ss_n),
        .sclk        (sclk),
        .mosi        (mosi),
        .joy_x       (joy_x),
        .joy_y       (joy_y),
        .btn         (btn),
        .sample_valid(sample_valid),
        .busy        (busy)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Slave model and frame monitor, both working at the falling clk edge.
    int          cur_rises = 0;
    int          low_cnt   = 0;
    int          low_run   = 0;
    int          exp_run   = 0;
    int          sv_total  = 0;
    logic [39:0] mosi_sr   = '0;
    logic [39:0] sl_sr     = '0;
    bit          gap_bad   = 1'b0;
    bit          prev_ss   = 1'b1;
    bit          prev_sclk = 1'b0;
    logic [5:0]  r6a, r6b;
    logic [4:0]  r5;

    always @(negedge clk) begin
        if (!ss_n && prev_ss) begin
            cur_rises = 0;
            low_cnt   = 0;
            low_run   = 0;
            mosi_sr   = '0;
            gap_bad   = 1'b0;
            r6a       = 6'($urandom);
            r6b       = 6'($urandom);
            r5        = 5'($urandom);
            sl_sr     = {sl_x[7:0], r6a, sl_x[9:8], sl_y[7:0], r6b, sl_y[9:8], r5, sl_b};
            miso      = sl_sr[39];
        end
        if (!ss_n) begin
            low_cnt++;
            if (sclk && !prev_sclk) begin
                cur_rises++;
                mosi_sr = {mosi_sr[38:0], mosi};
                if (cur_rises > 1) begin
                    exp_run = (cur_rises % 8 == 1) ? int'(BYTE_GAP + CLK_DIV) : int'(CLK_DIV);
                    if (low_run != exp_run) gap_bad = 1'b1;
                end
                low_run = 0;
            end
            if (!sclk) low_run++;
            if (!sclk && prev_sclk) begin
                sl_sr = {sl_sr[38:0], 1'b0};
                miso  = sl_sr[39];
            end
        end
        if (ss_n && !prev_ss && clr_n) begin
            frame_q.push_back('{rises: 32'(cur_rises), low: 32'(low_cnt), b0: mosi_sr[39:32],
                                rest: mosi_sr[31:0], gap_bad: gap_bad});
        end
        if (sample_valid) sv_total++;
        prev_ss   = ss_n;
        prev_sclk = sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Driver: program the slave and LEDs for the next frame and predict its result.
    task automatic prep(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b,
                        input logic [1:0] l);
        sl_x = x;
        sl_y = y;
        sl_b = b;
        led  = l;
        m_x  = AVG_EN ? 10'((int'(m_x) + int'(x)) / 2) : x;
        m_y  = AVG_EN ? 10'((int'(m_y) + int'(y)) / 2) : y;
        exp_q.push_back({m_x, m_y, b});
        exp_b0_q.push_back({6'b100000, l});
    endtask

    task automatic wait_ss_low();
        for (int i = 0; i < 3000 && ss_n; i++) @(negedge clk);
    endtask

    task automatic finish_frame(input bit chg, input logic [1:0] nl);
        bit          got;
        logic [22:0] e;
        logic [7:0]  eb0;
        frame_t      f;
        got = 1'b0;
        if (chg) begin
            wait_ss_low();
            repeat (40) @(negedge clk);
            led = nl;
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                got = 1'b1;
                break;
            end
        end
        frames_done++;
        check("sv_seen", 32'(got), 1);
        e   = exp_q.pop_front();
        eb0 = exp_b0_q.pop_front();
        if (got) begin
            check("joy_x", 32'(joy_x), 32'(e[22:13]));
            check("joy_y", 32'(joy_y), 32'(e[12:3]));
            check("btn", 32'(btn), 32'(e[2:0]));
            @(negedge clk);
            check("sv_width", 32'(sample_valid), 0);
            check("joy_x_hold", 32'(joy_x), 32'(e[22:13]));
            check("frame_seen", 32'(frame_q.size()), 1);
            if (frame_q.size() > 0) begin
                f = frame_q.pop_front();
                check("sclk_rises", f.rises, 40);
                check("ss_low_len", f.low, FRAME_LOW);
                check("mosi_byte0", 32'(f.b0), 32'(eb0));
                check("mosi_bytes1_4", f.rest, 0);
                check("sclk_gap_low", 32'(f.gap_bad), 0);
            end
        end
    endtask

    task automatic hold_reset();
        clr_n = 1'b0;
        m_x   = 10'd512;
        m_y   = 10'd512;
        exp_q.delete();
        exp_b0_q.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic release_and_check_poll();
        int sv_base;
        sv_base = sv_total;
        @(negedge clk);
        clr_n = 1'b1;
        repeat (POLL_GAP - 1) @(negedge clk);
        check("idle_ss_n", 32'(ss_n), 1);
        check("idle_busy", 32'(busy), 0);
        check("idle_no_sv", 32'(sv_total - sv_base), 0);
        @(negedge clk);
        check("start_ss_n", 32'(ss_n), 0);
        check("start_busy", 32'(busy), 1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ss_n"}, 32'(ss_n), 1);
        check({tag, "_sclk"}, 32'(sclk), 0);
        check({tag, "_mosi"}, 32'(mosi), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_sv"}, 32'(sample_valid), 0);
        check({tag, "_joy_x"}, 32'(joy_x), 512);
        check({tag, "_joy_y"}, 32'(joy_y), 512);
        check({tag, "_btn"}, 32'(btn), 0);
    endtask

    initial begin
        // Reset, then the directed frame from the joystick datasheet example.
        hold_reset();
        check_reset_values("rst");
        prep(10'h3A5, 10'h012, 3'b101, 2'b10);
        release_and_check_poll();
        finish_frame(1'b0, 2'b00);

        // Randomised frames.
        for (int i = 0; i < 4; i++) begin
            prep(10'($urandom), 10'($urandom), 3'($urandom), 2'($urandom));
            finish_frame(1'b0, 2'b00);
        end
        prep(10'd0, 10'd1023, 3'b000, 2'b01);
        finish_frame(1'b0, 2'b00);

        // LED change mid-frame only affects the following frame.
        prep(10'($urandom), 10'($urandom), 3'($urandom), 2'b00);
        finish_frame(1'b1, 2'b11);
        prep(10'($urandom), 10'($urandom), 3'($urandom), 2'b11);
        finish_frame(1'b0, 2'b00);

        // Reset during byte 2 discards the frame.
        prep(10'($urandom), 10'($urandom), 3'($urandom), 2'($urandom));
        wait_ss_low();
        for (int i = 0; i < 3000 && !(cur_rises >= 17 && !ss_n); i++) @(negedge clk);
        check("reached_byte2", 32'(cur_rises >= 17 && !ss_n), 1);
        #1;
        clr_n = 1'b0;
        #1;
        check_reset_values("midrst");
        hold_reset();
        check("midrst_no_frame", 32'(frame_q.size()), 0);

        // Two frames at full-scale X after reset.
        prep(10'd1023, 10'($urandom), 3'($urandom), 2'($urandom));
        release_and_check_poll();
        finish_frame(1'b0, 2'b00);
        prep(10'd1023, 10'($urandom), 3'($urandom), 2'($urandom));
        finish_frame(1'b0, 2'b00);

        repeat (5) @(negedge clk);
        check("sv_total", 32'(sv_total), 32'(frames_done));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
